// File: rtl/timer_pkg.sv
// Shared definitions for the timer interrupt stage.
//   CNT_W          counter / compare width
//   INT_MATCH_BIT  int_st / int_en bit of the compare-match source
//   INT_OVF_BIT    int_st / int_en bit of the counter-overflow source
//   match_state_t  states of the compare-match edge detector
package timer_pkg;

    localparam int CNT_W         = 64;
    localparam int INT_MATCH_BIT = 0;
    localparam int INT_OVF_BIT   = 1;

    typedef enum logic {
        ARMED   = 1'b0,
        MATCHED = 1'b1
    } match_state_t;

endpackage

// File: rtl/timer_match_fsm.sv
// Compare-match edge detector: turns a level "cnt == tcmp" into a single
// event, so a compare held true (halted counter, slow divider) raises the
// match status only once.
//
//   state   | meaning
//   --------+--------------------------------------------------------
//   ARMED   | compare not true last cycle; next eq=1 is a new match
//   MATCHED | match already reported; wait for eq=0 before re-arming
//
// Ports:
//   clk        system clock
//   rst        asynchronous reset, active-high
//   eq         live compare result
//   match_evt  one-cycle match event (combinational, valid for this edge)
import timer_pkg::*;

module timer_match_fsm (
    input  logic clk,
    input  logic rst,
    input  logic eq,
    output logic match_evt
);

    match_state_t state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ARMED;
        end else begin
            case (state)
                ARMED:   if (eq)  state <= MATCHED;
                MATCHED: if (!eq) state <= ARMED;
                default: state <= ARMED;
            endcase
        end
    end

    // The event must be seen at the same edge where eq is first true so the
    // status bit sets at that edge; hence it is decoded from the state.
    assign match_evt = (state == ARMED) && eq;

endmodule

// File: rtl/timer_int_ctrl.sv
// Timer interrupt stage: compare match and wrap-around detection, sticky
// write-1-to-clear status, enable masking and the registered tim_int output.
//
// Ports:
//   clk          system clock
//   rst          asynchronous reset, active-high
//   cnt          current counter value
//   tcmp         compare value
//   cnt_clr      counter clear strobe (a clear to 0 is not an overflow)
//   int_en       source enables: bit0 match, bit1 overflow
//   tisr_wr_sel  APB write to TISR this cycle
//   wdata        APB write data (only bits 1:0 used)
//   pstrb        APB byte strobes (only bit 0 used)
//   halt_ack     counter halted in debug
//   int_st       sticky status: bit0 match, bit1 overflow
//   tim_int      registered interrupt request
//
// Build option:
//   TIMER_INT_DBG_MASK_EN  when defined, halt_ack=1 forces tim_int low at the
//                          next edge; status still latches and clears.
import timer_pkg::*;

module timer_int_ctrl #(
    parameter int CNT_W  = timer_pkg::CNT_W,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CNT_W-1:0]  cnt,
    input  logic [CNT_W-1:0]  tcmp,
    input  logic              cnt_clr,
    input  logic [1:0]        int_en,
    input  logic              tisr_wr_sel,
    input  logic [DATA_W-1:0] wdata,
    input  logic [3:0]        pstrb,
    input  logic              halt_ack,
    output logic [1:0]        int_st,
    output logic              tim_int
);

    logic             eq;
    logic             match_evt;
    logic             ovf_evt;
    logic [CNT_W-1:0] cnt_prev;
    logic             cnt_prev_vld;
    logic [1:0]       st_set;
    logic [1:0]       st_clr;
    logic             tim_int_nxt;

    assign eq = (cnt == tcmp);

    timer_match_fsm u_match_fsm (
        .clk       (clk),
        .rst       (rst),
        .eq        (eq),
        .match_evt (match_evt)
    );

    // cnt_prev_vld keeps the first cycle after reset from comparing against
    // the reset value of cnt_prev.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_prev     <= '0;
            cnt_prev_vld <= 1'b0;
        end else begin
            cnt_prev     <= cnt;
            cnt_prev_vld <= 1'b1;
        end
    end

    assign ovf_evt = cnt_prev_vld && (cnt_prev == {CNT_W{1'b1}})
                     && (cnt == '0) && !cnt_clr;

    always_comb begin
        st_set                = 2'b00;
        st_set[INT_MATCH_BIT] = match_evt;
        st_set[INT_OVF_BIT]   = ovf_evt;
    end

    assign st_clr = {2{tisr_wr_sel & pstrb[0]}} & wdata[1:0];

    // Set has priority over a clear in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            int_st <= 2'b00;
        end else begin
            int_st <= st_set | (int_st & ~st_clr);
        end
    end

    always_comb begin
        tim_int_nxt = |(int_st & int_en);
`ifdef TIMER_INT_DBG_MASK_EN
        if (halt_ack) begin
            tim_int_nxt = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tim_int <= 1'b0;
        end else begin
            tim_int <= tim_int_nxt;
        end
    end

    // Inputs that carry no function in this block.
    logic unused_inputs;
`ifdef TIMER_INT_DBG_MASK_EN
    assign unused_inputs = ^{wdata[DATA_W-1:2], pstrb[3:1]};
`else
    assign unused_inputs = ^{wdata[DATA_W-1:2], pstrb[3:1], halt_ack};
`endif

endmodule
